redmule_tcdm_arbiter: RTL and testbench



---
 rtl/redmule_pkg.sv | 12 +
 rtl/redmule_arb_id_fifo.sv | 51 +++++
 rtl/redmule_tcdm_arbiter.sv | 153 +++++++++++++++
 tb/tb_redmule_tcdm_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared types and default sizing for the RedMulE TCDM arbiter.
package redmule_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } redmule_arb_mode_e;

  localparam int unsigned RedmuleArbNumCh          = 4;
  localparam int unsigned RedmuleArbMaxOutstanding = 4;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// In-order FIFO of channel IDs for outstanding reads; Depth must be a power of 2.
module redmule_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// N-channel TCDM arbiter (round-robin / fixed priority) with in-order read response routing.
// Optional per-channel performance counters: define REDMULE_TCDM_ARB_PERF_EN.
module redmule_tcdm_arbiter
  import redmule_pkg::*;
#(
  parameter int unsigned NumCh          = RedmuleArbNumCh,
  parameter int unsigned DW             = 288,
  parameter int unsigned AW             = 32,
  parameter int unsigned MaxOutstanding = RedmuleArbMaxOutstanding,
  localparam int unsigned IdxW = $clog2(NumCh),
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1),
  localparam int unsigned BW   = DW / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          mode_i,
  input  logic [NumCh-1:0]              ch_req_i,
  input  logic [NumCh-1:0]              ch_wen_i,
  input  logic [NumCh-1:0][AW-1:0]      ch_add_i,
  input  logic [NumCh-1:0][DW-1:0]      ch_data_i,
  input  logic [NumCh-1:0][BW-1:0]      ch_be_i,
  output logic [NumCh-1:0]              ch_gnt_o,
  output logic [NumCh-1:0]              ch_r_valid_o,
  input  logic [NumCh-1:0]              ch_r_ready_i,
  output logic [DW-1:0]                 ch_r_data_o,
  output logic                          tcdm_req_o,
  output logic                          tcdm_wen_o,
  output logic [AW-1:0]                 tcdm_add_o,
  output logic [DW-1:0]                 tcdm_data_o,
  output logic [BW-1:0]                 tcdm_be_o,
  input  logic                          tcdm_gnt_i,
  input  logic                          tcdm_r_valid_i,
  input  logic [DW-1:0]                 tcdm_r_data_i,
  output logic                          tcdm_r_ready_o,
  output logic [CntW-1:0]               outstanding_o,
`ifdef REDMULE_TCDM_ARB_PERF_EN
  output logic [NumCh-1:0][31:0]        perf_gnt_cnt_o,
  output logic [NumCh-1:0][31:0]        perf_stall_cnt_o,
`endif
  output logic                          err_o
);

  redmule_arb_mode_e arb_mode;
  logic [IdxW-1:0]   rr_ptr_q, winner, head;
  logic [NumCh-1:0]  eligible;
  logic              any_elig, accept, push, pop, fifo_full, fifo_empty, err_q;

  assign arb_mode = redmule_arb_mode_e'(mode_i);

  // Full check uses registered occupancy only, so no r_valid -> gnt path exists.
  assign eligible = ch_req_i & (~ch_wen_i | {NumCh{~fifo_full}});
  assign any_elig = |eligible;

  always_comb begin
    int unsigned idx;
    winner = '0;
    idx    = 0;
    if (arb_mode == ARB_FIXED) begin
      for (int i = NumCh - 1; i >= 0; i--) begin
        if (eligible[i]) winner = IdxW'(i);
      end
    end else begin
      for (int unsigned k = NumCh; k > 0; k--) begin
        idx = (32'(rr_ptr_q) + k - 1) % NumCh;
        if (eligible[idx]) winner = IdxW'(idx);
      end
    end
  end

  always_comb begin
    ch_gnt_o    = '0;
    tcdm_req_o  = any_elig;
    tcdm_wen_o  = 1'b0;
    tcdm_add_o  = '0;
    tcdm_data_o = '0;
    tcdm_be_o   = '0;
    if (any_elig) begin
      tcdm_wen_o       = ch_wen_i[winner];
      tcdm_add_o       = ch_add_i[winner];
      tcdm_data_o      = ch_data_i[winner];
      tcdm_be_o        = ch_be_i[winner];
      ch_gnt_o[winner] = tcdm_gnt_i;
    end
  end

  assign accept = any_elig & tcdm_gnt_i;
  assign push   = accept & ch_wen_i[winner];

  always_comb begin
    ch_r_valid_o   = '0;
    tcdm_r_ready_o = 1'b1;
    pop            = 1'b0;
    if (!fifo_empty) begin
      ch_r_valid_o[head] = tcdm_r_valid_i;
      tcdm_r_ready_o     = ch_r_ready_i[head];
      pop                = tcdm_r_valid_i & ch_r_ready_i[head];
    end
  end

  assign ch_r_data_o = tcdm_r_data_i;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept && arb_mode == ARB_RR) begin
        rr_ptr_q <= (32'(winner) == NumCh - 1) ? '0 : winner + IdxW'(1);
      end
      if (fifo_empty && tcdm_r_valid_i) err_q <= 1'b1;
    end
  end

  redmule_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

`ifdef REDMULE_TCDM_ARB_PERF_EN
  logic [NumCh-1:0][31:0] gnt_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (ch_gnt_o[i] && gnt_cnt_q[i] != '1) gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
        if (ch_req_i[i] && !ch_gnt_o[i] && stall_cnt_q[i] != '1) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign perf_gnt_cnt_o   = gnt_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Directed bench for redmule_tcdm_arbiter: vector table for arbitration, sequences for the FIFO.
module tb_redmule_tcdm_arbiter;

  localparam int unsigned NumCh = 4;
  localparam int unsigned DW    = 288;
  localparam int unsigned AW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned CntW  = 3;

  logic                     clk_i = 1'b0;
  logic                     rst_i, clear_i, mode_i;
  logic [NumCh-1:0]         ch_req_i, ch_wen_i, ch_gnt_o, ch_r_valid_o, ch_r_ready_i;
  logic [NumCh-1:0][AW-1:0] ch_add_i;
  logic [NumCh-1:0][DW-1:0] ch_data_i;
  logic [NumCh-1:0][BW-1:0] ch_be_i;
  logic [DW-1:0]            ch_r_data_o, tcdm_data_o, tcdm_r_data_i;
  logic                     tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_ready_o;
  logic [AW-1:0]            tcdm_add_o;
  logic [BW-1:0]            tcdm_be_o;
  logic [CntW-1:0]          outstanding_o;
  logic                     err_o;
`ifdef REDMULE_TCDM_ARB_PERF_EN
  logic [NumCh-1:0][31:0]   perf_gnt_cnt_o, perf_stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  redmule_tcdm_arbiter #(
    .NumCh          (NumCh),
    .DW             (DW),
    .AW             (AW),
    .MaxOutstanding (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .mode_i           (mode_i),
    .ch_req_i         (ch_req_i),
    .ch_wen_i         (ch_wen_i),
    .ch_add_i         (ch_add_i),
    .ch_data_i        (ch_data_i),
    .ch_be_i          (ch_be_i),
    .ch_gnt_o         (ch_gnt_o),
    .ch_r_valid_o     (ch_r_valid_o),
    .ch_r_ready_i     (ch_r_ready_i),
    .ch_r_data_o      (ch_r_data_o),
    .tcdm_req_o       (tcdm_req_o),
    .tcdm_wen_o       (tcdm_wen_o),
    .tcdm_add_o       (tcdm_add_o),
    .tcdm_data_o      (tcdm_data_o),
    .tcdm_be_o        (tcdm_be_o),
    .tcdm_gnt_i       (tcdm_gnt_i),
    .tcdm_r_valid_i   (tcdm_r_valid_i),
    .tcdm_r_data_i    (tcdm_r_data_i),
    .tcdm_r_ready_o   (tcdm_r_ready_o),
    .outstanding_o    (outstanding_o),
`ifdef REDMULE_TCDM_ARB_PERF_EN
    .perf_gnt_cnt_o   (perf_gnt_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .err_o            (err_o)
  );

  typedef struct {
    logic             mode;
    logic [NumCh-1:0] req;
    logic [NumCh-1:0] wen;
    logic             tgnt;
    logic [NumCh-1:0] exp_gnt;
    logic             exp_treq;
    int unsigned      exp_idx;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic go_idle();
    ch_req_i       = '0;
    ch_wen_i       = '0;
    tcdm_gnt_i     = 1'b1;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    ch_r_ready_i   = '1;
  endtask

  task automatic do_reset();
    go_idle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
  endtask

  logic [DW-1:0] resp_data [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    clear_i = 1'b0;
    mode_i  = 1'b0;
    go_idle();
    for (int i = 0; i < NumCh; i++) begin
      ch_add_i[i]  = 32'h1000_0000 + 32'(i) * 32'h10;
      ch_data_i[i] = {9{32'hA000_0000 + 32'(i)}};
      ch_be_i[i]   = '1;
    end
    for (int j = 0; j < 3; j++) resp_data[j] = {9{32'hD000_0000 + 32'(j)}};

    // Sequential vectors starting from rr_ptr = 0, all writes unless noted.
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 1};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 3};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 0};
    vecs[5]  = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1};
    vecs[6]  = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1};
    vecs[7]  = '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1};
    vecs[8]  = '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b1, 3};
    vecs[9]  = '{1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0000, 1'b1, 1};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};
    vecs[11] = '{1'b1, 4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2};

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    chk("rst_outstanding", DW'(outstanding_o), 0);
    chk("rst_err", DW'(err_o), 0);
    chk("rst_r_ready", DW'(tcdm_r_ready_o), 1);
    chk("rst_treq", DW'(tcdm_req_o), 0);
    chk("rst_gnt", DW'(ch_gnt_o), 0);

    for (int i = 0; i < 12; i++) begin
      mode_i     = vecs[i].mode;
      ch_req_i   = vecs[i].req;
      ch_wen_i   = vecs[i].wen;
      tcdm_gnt_i = vecs[i].tgnt;
      #1;
      chk($sformatf("vec%0d_gnt", i), DW'(ch_gnt_o), DW'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_treq", i), DW'(tcdm_req_o), DW'(vecs[i].exp_treq));
      chk($sformatf("vec%0d_add", i), DW'(tcdm_add_o),
          vecs[i].exp_treq ? DW'(ch_add_i[vecs[i].exp_idx]) : '0);
      chk($sformatf("vec%0d_data", i), tcdm_data_o,
          vecs[i].exp_treq ? ch_data_i[vecs[i].exp_idx] : '0);
      next_cycle();
    end

    // Outstanding limit: channel 2 reads with no responses
    do_reset();
    mode_i   = 1'b1;
    ch_req_i = 4'b0100;
    ch_wen_i = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lim_gnt%0d", k), DW'(ch_gnt_o), DW'(4'b0100));
      next_cycle();
    end
    chk("lim_outstanding", DW'(outstanding_o), 4);
    chk("lim_5th_gnt", DW'(ch_gnt_o), 0);
    chk("lim_5th_treq", DW'(tcdm_req_o), 0);
    // Same-cycle pop must not free a slot; a write still goes through
    tcdm_r_valid_i = 1'b1;
    ch_req_i       = 4'b0101;
    #1;
    chk("lim_pop_rvalid", DW'(ch_r_valid_o), DW'(4'b0100));
    chk("lim_pop_gnt", DW'(ch_gnt_o), DW'(4'b0001));
    chk("lim_pop_wen", DW'(tcdm_wen_o), 0);
    next_cycle();
    tcdm_r_valid_i = 1'b0;
    ch_req_i       = 4'b0100;
    #1;
    chk("lim_after_pop_cnt", DW'(outstanding_o), 3);
    chk("lim_after_pop_gnt", DW'(ch_gnt_o), DW'(4'b0100));
    next_cycle();
    chk("lim_refill_cnt", DW'(outstanding_o), 4);

    // In-order routing of reads from channels 0, 1, 2
    do_reset();
    mode_i   = 1'b1;
    ch_wen_i = 4'b1111;
    for (int j = 0; j < 3; j++) begin
      ch_req_i = 4'(1 << j);
      #1;
      chk($sformatf("ord_gnt%0d", j), DW'(ch_gnt_o), DW'(4'(1 << j)));
      chk($sformatf("ord_twen%0d", j), DW'(tcdm_wen_o), 1);
      next_cycle();
    end
    ch_req_i = '0;
    chk("ord_outstanding", DW'(outstanding_o), 3);
    for (int j = 0; j < 3; j++) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = resp_data[j];
      #1;
      chk($sformatf("ord_rvalid%0d", j), DW'(ch_r_valid_o), DW'(4'(1 << j)));
      chk($sformatf("ord_rdata%0d", j), ch_r_data_o, resp_data[j]);
      next_cycle();
    end
    tcdm_r_valid_i = 1'b0;
    #1;
    chk("ord_drained", DW'(outstanding_o), 0);
    chk("ord_no_err", DW'(err_o), 0);

    // Response backpressure on channel 1
    do_reset();
    ch_req_i = 4'b0010;
    ch_wen_i = 4'b0010;
    next_cycle();
    ch_req_i       = '0;
    tcdm_r_valid_i = 1'b1;
    tcdm_r_data_i  = resp_data[1];
    ch_r_ready_i   = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_rready%0d", k), DW'(tcdm_r_ready_o), 0);
      chk($sformatf("bp_rvalid%0d", k), DW'(ch_r_valid_o), DW'(4'b0010));
      next_cycle();
    end
    chk("bp_hold_cnt", DW'(outstanding_o), 1);
    ch_r_ready_i = '1;
    #1;
    chk("bp_release_rready", DW'(tcdm_r_ready_o), 1);
    next_cycle();
    tcdm_r_valid_i = 1'b0;
    chk("bp_popped_cnt", DW'(outstanding_o), 0);

    // Response in the same cycle as its read is accepted is an error
    do_reset();
    ch_req_i       = 4'b0001;
    ch_wen_i       = 4'b0001;
    tcdm_r_valid_i = 1'b1;
    #1;
    chk("emp_rvalid", DW'(ch_r_valid_o), 0);
    chk("emp_rready", DW'(tcdm_r_ready_o), 1);
    next_cycle();
    go_idle();
    #1;
    chk("emp_err", DW'(err_o), 1);
    chk("emp_cnt", DW'(outstanding_o), 1);
    clear_i = 1'b1;
    next_cycle();
    clear_i = 1'b0;
    chk("emp_clear_err", DW'(err_o), 0);
    chk("emp_clear_cnt", DW'(outstanding_o), 0);

    // Reset mid-flight discards IDs; late response flags err_o
    do_reset();
    ch_wen_i = 4'b0011;
    ch_req_i = 4'b0001;
    next_cycle();
    ch_req_i = 4'b0010;
    next_cycle();
    ch_req_i = '0;
    chk("mid_cnt_before", DW'(outstanding_o), 2);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    chk("mid_cnt_after", DW'(outstanding_o), 0);
    tcdm_r_valid_i = 1'b1;
    #1;
    chk("mid_late_rvalid", DW'(ch_r_valid_o), 0);
    chk("mid_late_rready", DW'(tcdm_r_ready_o), 1);
    next_cycle();
    tcdm_r_valid_i = 1'b0;
    chk("mid_err_set", DW'(err_o), 1);
    next_cycle();
    chk("mid_err_sticky", DW'(err_o), 1);
    clear_i = 1'b1;
    next_cycle();
    clear_i = 1'b0;
    chk("mid_err_cleared", DW'(err_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
